// File: rtl/spi_rd_sched.sv
// spi_rd_sched: two-requester scheduler for SPI register reads.
// Grants one requester and then runs a chip-select frame on the SPI pins.
// The address byte goes out on MOSI, LSB first. DSIZE data bits are then
// sampled from MISO, LSB first. The assembled word is returned with the
// requester id.
// Optional macro SPI_RR_ARB_EN: when defined, ties are settled round-robin.
// When undefined (the default build), req0 has fixed priority.
module spi_rd_sched #(
  parameter int DSIZE  = 8,
  parameter int CS_GAP = 2
) (
  input  logic             spi_clk,
  input  logic             spi_rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [DSIZE-1:0] addr0,
  input  logic [DSIZE-1:0] addr1,
  output logic             gnt0,
  output logic             gnt1,
  output logic [DSIZE-1:0] rd_data,
  output logic             rd_valid,
  output logic             rd_id,
  output logic             busy,
  output logic             spi_cs,
  output logic             spi_mosi_out,
  input  logic             spi_miso_in
);

  localparam int BW = (DSIZE > 1) ? $clog2(DSIZE) : 1;
  localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DSIZE - 1);
  localparam logic [GW-1:0] LAST_GAP = GW'(CS_GAP - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    ADDR  = 3'd2,
    DATA  = 3'd3,
    GAP   = 3'd4
  } state_t;

  state_t           state_reg;
  logic [BW-1:0]    cnt_reg;
  logic [GW-1:0]    gap_cnt_reg;
  logic [DSIZE-1:0] addr_reg;
  logic [DSIZE-1:0] shift_reg;
  logic             id_reg;

  logic             arb_slot;
  logic             grant_win;
  logic             grant_sel;
  logic [DSIZE-1:0] word_next;

  // Shift register with the bit currently on MISO merged in at position cnt.
  // On the last data bit this gives the complete word.
  genvar gi;
  generate
    for (gi = 0; gi < DSIZE; gi++) begin : g_word
      assign word_next[gi] = (cnt_reg == BW'(gi)) ? spi_miso_in : shift_reg[gi];
    end
  endgenerate

  // A grant may be issued while idle, or on the final cycle of the CS gap.
  // The second case keeps back-to-back reads at the minimum spacing.
  assign arb_slot  = (state_reg == IDLE) ||
                     ((state_reg == GAP) && (gap_cnt_reg == LAST_GAP));
  assign grant_win = arb_slot && (req0 || req1);

`ifdef SPI_RR_ARB_EN
  logic last_id_reg;

  // On a tie the requester granted last time loses. A lone requester always wins.
  assign grant_sel = (req0 && req1) ? ~last_id_reg : req1;

  // Record the last grant. Reset points at requester 1 so that requester 0 wins the first tie.
  always_ff @(posedge spi_clk) begin
    if (spi_rst) begin
      last_id_reg <= 1'b1;
    end else if (grant_win) begin
      last_id_reg <= grant_sel;
    end
  end
`else
  // Fixed priority: requester 1 is selected only when requester 0 is not asking.
  assign grant_sel = ~req0;
`endif

  // Sequencer. It issues the grant, the frame, the address shift-out, the data capture and the CS gap.
  always_ff @(posedge spi_clk) begin
    if (spi_rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      gap_cnt_reg  <= '0;
      addr_reg     <= '0;
      shift_reg    <= '0;
      id_reg       <= 1'b0;
      gnt0         <= 1'b0;
      gnt1         <= 1'b0;
      rd_data      <= '0;
      rd_valid     <= 1'b0;
      rd_id        <= 1'b0;
      busy         <= 1'b0;
      spi_cs       <= 1'b1;
      spi_mosi_out <= 1'b0;
    end else begin
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      rd_valid <= 1'b0;

      case (state_reg)
        IDLE: begin
          spi_cs       <= 1'b1;
          spi_mosi_out <= 1'b0;
        end
        SETUP: begin
          spi_cs       <= 1'b0;
          spi_mosi_out <= 1'b0;
          cnt_reg      <= '0;
          state_reg    <= ADDR;
        end
        ADDR: begin
          spi_mosi_out <= addr_reg[cnt_reg];
          if (cnt_reg == LAST_BIT) begin
            cnt_reg   <= '0;
            state_reg <= DATA;
          end else begin
            cnt_reg <= cnt_reg + BW'(1);
          end
        end
        DATA: begin
          spi_mosi_out <= 1'b0;
          shift_reg    <= word_next;
          if (cnt_reg == LAST_BIT) begin
            rd_data     <= word_next;
            rd_valid    <= 1'b1;
            rd_id       <= id_reg;
            spi_cs      <= 1'b1;
            cnt_reg     <= '0;
            gap_cnt_reg <= '0;
            state_reg   <= GAP;
          end else begin
            cnt_reg <= cnt_reg + BW'(1);
          end
        end
        GAP: begin
          spi_cs <= 1'b1;
          if (gap_cnt_reg == LAST_GAP) begin
            gap_cnt_reg <= '0;
            busy        <= 1'b0;
            state_reg   <= IDLE;
          end else begin
            gap_cnt_reg <= gap_cnt_reg + GW'(1);
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase

      // A grant overrides the idle/gap-exit updates made above.
      if (grant_win) begin
        gnt0      <= ~grant_sel;
        gnt1      <= grant_sel;
        addr_reg  <= grant_sel ? addr1 : addr0;
        id_reg    <= grant_sel;
        busy      <= 1'b1;
        state_reg <= SETUP;
      end
    end
  end

endmodule

// File: tb/tb_spi_rd_sched.sv
// Testbench for spi_rd_sched.
// The slave model decodes the address from MOSI and answers with mem[addr] on MISO.
// The monitor predicts grants, frame timing and returned words from cycle arithmetic.
module tb_spi_rd_sched;

  localparam int DSIZE   = 8;
  localparam int CS_GAP  = 2;
  localparam int BW      = $clog2(DSIZE);
  localparam int RDLAT   = 2 * DSIZE + 1;
  localparam int SPACING = 2 * DSIZE + 1 + CS_GAP;

  logic             spi_clk;
  logic             spi_rst;
  logic             req0, req1;
  logic [DSIZE-1:0] addr0, addr1;
  logic             gnt0, gnt1;
  logic [DSIZE-1:0] rd_data;
  logic             rd_valid, rd_id, busy, spi_cs, spi_mosi_out, spi_miso_in;

  int total_cnt;
  int pass_cnt;

  logic [DSIZE-1:0] mem [2**DSIZE];

  typedef struct {
    logic             id;
    logic [DSIZE-1:0] addr;
    int               due;
  } exp_t;

  exp_t             sb[$];
  logic [DSIZE-1:0] slave_q[$];

  spi_rd_sched #(.DSIZE(DSIZE), .CS_GAP(CS_GAP)) dut (
    .spi_clk      (spi_clk),
    .spi_rst      (spi_rst),
    .req0         (req0),
    .req1         (req1),
    .addr0        (addr0),
    .addr1        (addr1),
    .gnt0         (gnt0),
    .gnt1         (gnt1),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .rd_id        (rd_id),
    .busy         (busy),
    .spi_cs       (spi_cs),
    .spi_mosi_out (spi_mosi_out),
    .spi_miso_in  (spi_miso_in)
  );

  initial spi_clk = 1'b0;
  always #5 spi_clk = ~spi_clk;

  task automatic check_bit(input string name, input logic act, input logic exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
  endtask

  task automatic check_word(input string name, input logic [DSIZE-1:0] act, input logic [DSIZE-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic expire(input string name);
    total_cnt++;
    $display("FAIL %s: bound expired without the expected event at %0t", name, $time);
  endtask

  // Slave model: count cycles with CS low, read the address from MOSI, then
  // drive mem[addr] LSB first. Outside the data window MISO carries junk bits.
  initial begin : slave
    int k;
    logic [DSIZE-1:0] sa;
    k = 0;
    sa = '0;
    spi_miso_in = 1'b0;
    forever begin
      @(negedge spi_clk);
      if (spi_cs) begin
        k = 0;
      end else begin
        k++;
        if (k >= 2 && k <= DSIZE + 1) sa[BW'(k - 2)] = spi_mosi_out;
        if (k == DSIZE + 1) slave_q.push_back(sa);
      end
      if (!spi_cs && k >= DSIZE + 1 && k <= 2 * DSIZE) spi_miso_in = mem[sa][BW'(k - DSIZE - 1)];
      else spi_miso_in = 1'($urandom);
    end
  end

  // Monitor and reference: predict grants from the request levels and free slots.
  // Predict frame timing from the last grant edge, and words from the memory image.
  initial begin : monitor
    int e, g, free_at;
    bit active, last_id, want, w, exp_valid;
    logic [DSIZE-1:0] exp_rd;
    exp_t ent;
    e = 0; g = 0; free_at = 0; active = 0; last_id = 1; exp_rd = '0;
    forever begin
      @(posedge spi_clk);
      #1;
      e++;
      if (spi_rst) begin
        check_bit("rst_gnt0", gnt0, 1'b0);
        check_bit("rst_gnt1", gnt1, 1'b0);
        check_bit("rst_rd_valid", rd_valid, 1'b0);
        check_bit("rst_spi_cs", spi_cs, 1'b1);
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_mosi", spi_mosi_out, 1'b0);
        check_bit("rst_rd_id", rd_id, 1'b0);
        check_word("rst_rd_data", rd_data, '0);
        active = 0; free_at = e + 1; last_id = 1; exp_rd = '0;
        sb.delete();
        slave_q.delete();
      end else begin
        want = (e >= free_at) && (req0 || req1);
`ifdef SPI_RR_ARB_EN
        if (req0 && req1) w = (last_id == 1'b0);
        else w = req1;
`else
        w = req0 ? 1'b0 : 1'b1;
`endif
        check_bit("gnt0", gnt0, want && !w);
        check_bit("gnt1", gnt1, want && w);
        if (want) begin
          g = e; active = 1; free_at = e + SPACING; last_id = w;
          ent.id = w;
          ent.addr = w ? addr1 : addr0;
          ent.due = e + RDLAT;
          sb.push_back(ent);
        end
        exp_valid = (sb.size() > 0) && (sb[0].due == e);
        check_bit("rd_valid", rd_valid, exp_valid);
        if (exp_valid) begin
          ent = sb.pop_front();
          exp_rd = mem[ent.addr];
          check_bit("rd_id", rd_id, ent.id);
          if (slave_q.size() == 0) expire("mosi_addr");
          else check_word("mosi_addr", slave_q.pop_front(), ent.addr);
        end
        check_word("rd_data", rd_data, exp_rd);
        check_bit("spi_cs", spi_cs, !(active && e >= g + 1 && e <= g + 2 * DSIZE));
        check_bit("busy", busy, active && e <= g + SPACING - 1);
        if (!(active && e >= g + 2 && e <= g + DSIZE + 1))
          check_bit("mosi_quiet", spi_mosi_out, 1'b0);
      end
    end
  end

  task automatic wait_gnt(input bit id, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge spi_clk);
      if (id ? gnt1 : gnt0) begin
        ok = 1;
        return;
      end
    end
    expire(id ? "wait_gnt1" : "wait_gnt0");
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      @(negedge spi_clk);
      if (!busy && !gnt0 && !gnt1) begin
        repeat (2) @(negedge spi_clk);
        return;
      end
    end
    expire("wait_idle");
  endtask

  task automatic requester(input bit id, input int n);
    bit ok;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(40, 0)) @(negedge spi_clk);
      if (id) begin addr1 = DSIZE'($urandom); req1 = 1'b1; end
      else    begin addr0 = DSIZE'($urandom); req0 = 1'b1; end
      wait_gnt(id, 3000, ok);
      if (id) req1 = 1'b0;
      else    req0 = 1'b0;
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    bit ok;
    int n, t, prev, cnt_g1, cnt_id1;
    logic [DSIZE-1:0] a85;
    total_cnt = 0;
    pass_cnt  = 0;
    spi_rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    addr0 = '0; addr1 = '0;
    for (int i = 0; i < 2**DSIZE; i++) mem[i] = DSIZE'($urandom);
    mem[8'h85] = 8'h3C;
    repeat (3) @(negedge spi_clk);
    spi_rst = 1'b0;

    // Directed single read: address 0x85, slave returns 0x3C.
    a85 = 8'h85;
    addr0 = a85;
    req0 = 1'b1;
    wait_gnt(0, 50, ok);
    req0 = 1'b0;
    for (int k = 1; k <= DSIZE + 1; k++) begin
      @(negedge spi_clk);
      if (k == 1) check_bit("dir_setup_mosi", spi_mosi_out, 1'b0);
      else check_bit("dir_mosi", spi_mosi_out, a85[BW'(k - 2)]);
      check_bit("dir_cs_low", spi_cs, 1'b0);
    end
    repeat (DSIZE - 1) @(negedge spi_clk);
    check_bit("dir_cs_last", spi_cs, 1'b0);
    @(negedge spi_clk);
    check_bit("dir_rd_valid", rd_valid, 1'b1);
    check_word("dir_rd_data", rd_data, 8'h3C);
    check_bit("dir_rd_id", rd_id, 1'b0);
    check_bit("dir_cs_high", spi_cs, 1'b1);
    $display("read addr=85 data=%0h id=%0d", rd_data, rd_id);

    // Tie with both requests held, starting from reset history.
    wait_idle();
    spi_rst = 1'b1;
    @(negedge spi_clk);
    spi_rst = 1'b0;
    addr0 = DSIZE'($urandom); addr1 = DSIZE'($urandom);
    req0 = 1'b1; req1 = 1'b1;
    n = 0;
    for (int i = 0; i < 200 && n < 4; i++) begin
      @(negedge spi_clk);
      if (gnt0 || gnt1) begin
`ifdef SPI_RR_ARB_EN
        check_bit("tie_order", gnt1, 1'(n % 2));
`else
        check_bit("tie_order", gnt1, 1'b0);
`endif
        $display("tie grant %0d -> requester %0d", n, gnt1);
        n++;
      end
    end
    if (n < 4) expire("tie_grants");
    req0 = 1'b0; req1 = 1'b0;

    // Continuous req1: grants are spaced exactly by the minimum interval.
    wait_idle();
    addr1 = DSIZE'($urandom);
    req1 = 1'b1;
    n = 0; t = 0; prev = 0;
    for (int i = 0; i < 200 && n < 3; i++) begin
      @(negedge spi_clk);
      t++;
      if (gnt1) begin
        if (n > 0) check_int("gap_spacing", t - prev, SPACING);
        prev = t;
        n++;
      end
    end
    if (n < 3) expire("gap_grants");
    req1 = 1'b0;

    // Reset in the middle of the data phase, with the request still held.
    wait_idle();
    addr0 = DSIZE'($urandom);
    req0 = 1'b1;
    wait_gnt(0, 50, ok);
    repeat (12) @(negedge spi_clk);
    spi_rst = 1'b1;
    @(negedge spi_clk);
    check_bit("midrst_cs", spi_cs, 1'b1);
    check_bit("midrst_busy", busy, 1'b0);
    check_bit("midrst_rd_valid", rd_valid, 1'b0);
    check_word("midrst_rd_data", rd_data, '0);
    spi_rst = 1'b0;
    wait_gnt(0, 10, ok);
    check_bit("midrst_regrant", ok, 1'b1);
    req0 = 1'b0;

    // Withdrawal: a one-cycle req1 pulse while busy must never be granted.
    wait_idle();
    addr0 = DSIZE'($urandom);
    req0 = 1'b1;
    wait_gnt(0, 50, ok);
    req0 = 1'b0;
    repeat (4) @(negedge spi_clk);
    addr1 = DSIZE'($urandom);
    req1 = 1'b1;
    @(negedge spi_clk);
    req1 = 1'b0;
    cnt_g1 = 0; cnt_id1 = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge spi_clk);
      if (gnt1) cnt_g1++;
      if (rd_valid && rd_id) cnt_id1++;
    end
    check_int("withdraw_gnt1", cnt_g1, 0);
    check_int("withdraw_rd_id1", cnt_id1, 0);

    // Randomized traffic from both requesters.
    fork
      requester(0, 15);
      requester(1, 15);
    join
    wait_idle();
    repeat (5) @(negedge spi_clk);
    check_int("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
